// File: rtl/ibex_alu_checker.sv
// ALU result monitor: recomputes ibex_alu outputs with a golden model and counts checks, skips and errors.
// Optional first-mismatch capture ports are built when IBEX_ALU_CHK_CAPTURE_EN is defined.

package ibex_pkg;
   typedef enum logic [6:0] {
      ALU_ADD, ALU_SUB,
      ALU_XOR, ALU_OR, ALU_AND, ALU_XNOR, ALU_ORN, ALU_ANDN,
      ALU_SRA, ALU_SRL, ALU_SLL, ALU_SRO, ALU_SLO, ALU_ROR, ALU_ROL,
      ALU_GREV, ALU_GORC, ALU_SHFL, ALU_UNSHFL,
      ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE,
      ALU_MIN, ALU_MINU, ALU_MAX, ALU_MAXU,
      ALU_SLT, ALU_SLTU
   } alu_op_e;
endpackage

module ibex_alu_checker #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned NUM_CHECKS = 12
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              done_i,
   input  logic              valid_i,
   input  ibex_pkg::alu_op_e operator_i,
   input  logic [31:0]       operand_a_i,
   input  logic [31:0]       operand_b_i,
   input  logic [31:0]       result_i,
   input  logic              cmp_result_i,
   input  logic              is_equal_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  check_cnt_o,
   output logic [CNT_W-1:0]  skip_cnt_o,
   output logic [CNT_W-1:0]  err_cnt_o
`ifdef IBEX_ALU_CHK_CAPTURE_EN
   ,
   output ibex_pkg::alu_op_e fail_op_o,
   output logic [31:0]       fail_a_o,
   output logic [31:0]       fail_b_o,
   output logic [31:0]       fail_got_o,
   output logic [31:0]       fail_exp_o
`endif
);
   import ibex_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e      state_q, state_d;
   logic        start_accept;

   logic        s1_valid;
   alu_op_e     s1_op;
   logic [31:0] s1_a, s1_b, s1_res;
   logic        s1_cmp, s1_eq;

   logic [31:0] exp_res;
   logic        exp_cmp;
   logic        is_cmp;
   logic        supported;
   logic        mismatch;
   logic [4:0]  shamt;

   assign start_accept = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_i) state_d = ST_RUN;
         ST_RUN: begin
            if (done_i || ((NUM_CHECKS != 0) && (check_cnt_o >= CNT_W'(NUM_CHECKS)))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: if (!s1_valid) state_d = ST_DONE;
         ST_DONE: if (start_i) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Stage 1: register the ALU inputs and outputs of the sampled cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_op    <= ALU_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_res   <= '0;
         s1_cmp   <= 1'b0;
         s1_eq    <= 1'b0;
      end else begin
         s1_valid <= valid_i && (state_q == ST_RUN);
         if (valid_i && (state_q == ST_RUN)) begin
            s1_op  <= operator_i;
            s1_a   <= operand_a_i;
            s1_b   <= operand_b_i;
            s1_res <= result_i;
            s1_cmp <= cmp_result_i;
            s1_eq  <= is_equal_i;
         end
      end
   end

   // Stage 2: golden model.
   always_comb begin
      exp_res   = '0;
      exp_cmp   = 1'b0;
      is_cmp    = 1'b0;
      supported = 1'b1;
      shamt     = s1_b[4:0];
      case (s1_op)
         ALU_ADD:  exp_res = s1_a + s1_b;
         ALU_SUB:  exp_res = s1_a - s1_b;
         ALU_XOR:  exp_res = s1_a ^ s1_b;
         ALU_OR:   exp_res = s1_a | s1_b;
         ALU_AND:  exp_res = s1_a & s1_b;
         ALU_XNOR: exp_res = ~(s1_a ^ s1_b);
         ALU_ORN:  exp_res = s1_a | ~s1_b;
         ALU_ANDN: exp_res = s1_a & ~s1_b;
         ALU_SLL:  exp_res = s1_a << shamt;
         ALU_SRL:  exp_res = s1_a >> shamt;
         ALU_SRA:  exp_res = $unsigned($signed(s1_a) >>> shamt);
         ALU_LT:   begin is_cmp = 1'b1; exp_cmp = $signed(s1_a) < $signed(s1_b);  end
         ALU_GE:   begin is_cmp = 1'b1; exp_cmp = $signed(s1_a) >= $signed(s1_b); end
         ALU_LTU:  begin is_cmp = 1'b1; exp_cmp = s1_a < s1_b;  end
         ALU_GEU:  begin is_cmp = 1'b1; exp_cmp = s1_a >= s1_b; end
         ALU_EQ:   begin is_cmp = 1'b1; exp_cmp = s1_a == s1_b; end
         ALU_NE:   begin is_cmp = 1'b1; exp_cmp = s1_a != s1_b; end
         default:  supported = 1'b0;
      endcase
      if (is_cmp) begin
         exp_res = {31'b0, exp_cmp};
      end
   end

   assign mismatch = supported &&
                     ((s1_res != exp_res) || (s1_eq != (s1_a == s1_b)) ||
                      (is_cmp && (s1_cmp != exp_cmp)));

   always_ff @(posedge clk_i) begin
      if (rst_i || start_accept) begin
         check_cnt_o <= '0;
         skip_cnt_o  <= '0;
         err_cnt_o   <= '0;
         err_o       <= 1'b0;
      end else if (s1_valid) begin
         if (supported) begin
            if (check_cnt_o != '1) check_cnt_o <= check_cnt_o + CNT_W'(1);
            if (mismatch) begin
               err_o <= 1'b1;
               if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
         end else if (skip_cnt_o != '1) begin
            skip_cnt_o <= skip_cnt_o + CNT_W'(1);
         end
      end
   end

`ifdef IBEX_ALU_CHK_CAPTURE_EN
   // err_o still low means this is the first mismatch since reset/start.
   always_ff @(posedge clk_i) begin
      if (rst_i || start_accept) begin
         fail_op_o  <= ALU_ADD;
         fail_a_o   <= '0;
         fail_b_o   <= '0;
         fail_got_o <= '0;
         fail_exp_o <= '0;
      end else if (s1_valid && mismatch && !err_o) begin
         fail_op_o  <= s1_op;
         fail_a_o   <= s1_a;
         fail_b_o   <= s1_b;
         fail_got_o <= s1_res;
         fail_exp_o <= exp_res;
      end
   end
`endif

   assign busy_o = (state_q == ST_RUN);
   assign done_o = (state_q == ST_DONE);
   assign pass_o = done_o && (err_cnt_o == '0);

endmodule

// File: tb/tb_ibex_alu_checker.sv
// Directed bench for ibex_alu_checker: per-vector expected outcome queue, counter model, immediate assertions.
module tb_ibex_alu_checker;
   import ibex_pkg::*;

   localparam int CNT_W = 16;

   logic              clk_i = 1'b0;
   logic              rst_i, start_i, done_i, valid_i;
   alu_op_e           operator_i;
   logic [31:0]       operand_a_i, operand_b_i, result_i;
   logic              cmp_result_i, is_equal_i;
   logic              busy_o, done_o, pass_o, err_o;
   logic [CNT_W-1:0]  check_cnt_o, skip_cnt_o, err_cnt_o;
`ifdef IBEX_ALU_CHK_CAPTURE_EN
   alu_op_e           fail_op_o;
   logic [31:0]       fail_a_o, fail_b_o, fail_got_o, fail_exp_o;
`endif

   int checks = 0;
   int errors = 0;

   // Outcome per vector: 0 = pass, 1 = mismatch, 2 = skipped.
   logic [1:0] exp_q[$];
   int m_chk, m_skip, m_err;
   logic m_errf;

   always #5 clk_i = ~clk_i;

   ibex_alu_checker #(.CNT_W(CNT_W), .NUM_CHECKS(12)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .done_i(done_i), .valid_i(valid_i),
      .operator_i(operator_i), .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
      .result_i(result_i), .cmp_result_i(cmp_result_i), .is_equal_i(is_equal_i),
      .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_o(err_o),
      .check_cnt_o(check_cnt_o), .skip_cnt_o(skip_cnt_o), .err_cnt_o(err_cnt_o)
`ifdef IBEX_ALU_CHK_CAPTURE_EN
      ,
      .fail_op_o(fail_op_o), .fail_a_o(fail_a_o), .fail_b_o(fail_b_o),
      .fail_got_o(fail_got_o), .fail_exp_o(fail_exp_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] model_kind(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] res, input logic cmp, input logic eq);
      logic [31:0] r;
      logic c;
      logic compare;
      r = 32'h0;
      c = 1'b0;
      compare = 1'b0;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a + (~b + 32'd1);
         ALU_XOR:  r = (a | b) & ~(a & b);
         ALU_OR:   r = a | b;
         ALU_AND:  r = a & b;
         ALU_XNOR: r = (a & b) | (~a & ~b);
         ALU_ORN:  r = a | ~b;
         ALU_ANDN: r = a & ~b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = (a >> b[4:0]) | (a[31] ? ~(32'hFFFF_FFFF >> b[4:0]) : 32'h0);
         ALU_LT:   begin compare = 1'b1; c = (a[31] != b[31]) ? a[31] : (a < b); end
         ALU_GE:   begin compare = 1'b1; c = !((a[31] != b[31]) ? a[31] : (a < b)); end
         ALU_LTU:  begin compare = 1'b1; c = a < b; end
         ALU_GEU:  begin compare = 1'b1; c = !(a < b); end
         ALU_EQ:   begin compare = 1'b1; c = (a == b); end
         ALU_NE:   begin compare = 1'b1; c = !(a == b); end
         default:  return 2'd2;
      endcase
      if (compare) begin
         if (cmp != c || res != {31'b0, c}) return 2'd1;
      end else if (res != r) begin
         return 2'd1;
      end
      if (eq != (a == b)) return 2'd1;
      return 2'd0;
   endfunction

   task automatic drive(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic cmp, input logic eq);
      operator_i = op; operand_a_i = a; operand_b_i = b;
      result_i = res; cmp_result_i = cmp; is_equal_i = eq;
      valid_i = 1'b1;
      exp_q.push_back(model_kind(op, a, b, res, cmp, eq));
   endtask

   task automatic retire();
      logic [1:0] k;
      k = exp_q.pop_front();
      if (k == 2'd2) m_skip++;
      else begin
         m_chk++;
         if (k == 2'd1) begin m_err++; m_errf = 1'b1; end
      end
   endtask

   task automatic check_counts(input string tag);
      chk({tag, ".check_cnt"}, 32'(check_cnt_o), 32'(m_chk));
      chk({tag, ".skip_cnt"},  32'(skip_cnt_o),  32'(m_skip));
      chk({tag, ".err_cnt"},   32'(err_cnt_o),   32'(m_err));
      chk({tag, ".err"},       32'(err_o),       32'(m_errf));
   endtask

   // One vector, then wait for its counter update (2 edges after valid_i).
   task automatic send(input string tag, input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic cmp, input logic eq);
      @(negedge clk_i);
      drive(op, a, b, res, cmp, eq);
      @(negedge clk_i);
      valid_i = 1'b0;
      @(negedge clk_i);
      if (exp_q.size() == 0) chk({tag, ".queue"}, 32'(exp_q.size()), 32'd1);
      else retire();
      check_counts(tag);
   endtask

   task automatic pulse_start();
      @(negedge clk_i); start_i = 1'b1;
      @(negedge clk_i); start_i = 1'b0;
      m_chk = 0; m_skip = 0; m_err = 0; m_errf = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (done_o) break;
         @(negedge clk_i);
      end
      chk({tag, ".done"}, 32'(done_o), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; start_i = 1'b0; done_i = 1'b0; valid_i = 1'b0;
      operator_i = ALU_ADD; operand_a_i = '0; operand_b_i = '0;
      result_i = '0; cmp_result_i = 1'b0; is_equal_i = 1'b0;
      m_chk = 0; m_skip = 0; m_err = 0; m_errf = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      chk("reset.busy", 32'(busy_o), 32'd0);
      chk("reset.done", 32'(done_o), 32'd0);
      chk("reset.pass", 32'(pass_o), 32'd0);
      check_counts("reset");

      // Valid in IDLE is dropped.
      @(negedge clk_i); operator_i = ALU_ADD; valid_i = 1'b1;
      @(negedge clk_i); valid_i = 1'b0;
      @(negedge clk_i);
      check_counts("idle_drop");

      // Run 1: twelve correct vectors reach DONE through NUM_CHECKS.
      pulse_start();
      chk("run1.busy", 32'(busy_o), 32'd1);
      send("add",  ALU_ADD,  32'd32,        32'd64,        32'd96,        1'b0, 1'b0);
      send("sub",  ALU_SUB,  32'd512,       32'd256,       32'd256,       1'b0, 1'b0);
      send("xor",  ALU_XOR,  32'hFFFFFF00,  32'h00FFFFFF,  32'hFF0000FF,  1'b0, 1'b0);
      send("or",   ALU_OR,   32'hF0F00000,  32'h00000F0F,  32'hF0F00F0F,  1'b0, 1'b0);
      send("and",  ALU_AND,  32'hFF00FF00,  32'h0FF00FF0,  32'h0F000F00,  1'b0, 1'b0);
      send("xnor", ALU_XNOR, 32'h12345678,  32'hFFFF0000,  32'h1234A987,  1'b0, 1'b0);
      send("orn",  ALU_ORN,  32'h000000FF,  32'h0000FFFF,  32'hFFFF00FF,  1'b0, 1'b0);
      send("andn", ALU_ANDN, 32'hFFFFFFFF,  32'h0000FFFF,  32'hFFFF0000,  1'b0, 1'b0);
      send("lt",   ALU_LT,   32'd32,        32'd64,        32'd1,         1'b1, 1'b0);
      send("ge",   ALU_GE,   32'd32,        32'd32,        32'd1,         1'b1, 1'b1);
      send("eq",   ALU_EQ,   32'd7,         32'd7,         32'd1,         1'b1, 1'b1);
      send("ne",   ALU_NE,   32'd7,         32'd8,         32'd1,         1'b1, 1'b0);
      wait_done("run1");
      chk("run1.pass", 32'(pass_o), 32'd1);
      chk("run1.check_cnt", 32'(check_cnt_o), 32'd12);
      chk("run1.busy_at_done", 32'(busy_o), 32'd0);

      // Run 2: injected errors, skip, signed/unsigned boundary, shifts; ended by done_i.
      pulse_start();
      check_counts("run2.cleared");
      send("sub_bad",  ALU_SUB, 32'd512,      32'd256, 32'h101,      1'b0, 1'b0);
      send("slt_skip", ALU_SLT, 32'd5,        32'd6,   32'd1,        1'b1, 1'b0);
      send("lt_neg",   ALU_LT,  32'hFFFFFFFF, 32'd1,   32'd0,        1'b0, 1'b0);
      send("ltu_big",  ALU_LTU, 32'hFFFFFFFF, 32'd1,   32'd0,        1'b0, 1'b0);
      send("sra",      ALU_SRA, 32'h80000000, 32'd4,   32'hF8000000, 1'b0, 1'b0);
      send("sll_wrap", ALU_SLL, 32'd1,        32'd33,  32'd2,        1'b0, 1'b0);
      send("srl",      ALU_SRL, 32'h80000000, 32'd31,  32'd1,        1'b0, 1'b0);
      send("eq_flag",  ALU_ADD, 32'd5,        32'd5,   32'd10,       1'b0, 1'b0);
      @(negedge clk_i); done_i = 1'b1;
      @(negedge clk_i); done_i = 1'b0;
      wait_done("run2");
      chk("run2.pass", 32'(pass_o), 32'd0);
      chk("run2.err_cnt", 32'(err_cnt_o), 32'd3);
      chk("run2.skip_cnt", 32'(skip_cnt_o), 32'd1);
`ifdef IBEX_ALU_CHK_CAPTURE_EN
      chk("cap.op",  32'(fail_op_o), 32'(ALU_SUB));
      chk("cap.a",   fail_a_o,   32'd512);
      chk("cap.b",   fail_b_o,   32'd256);
      chk("cap.got", fail_got_o, 32'h101);
      chk("cap.exp", fail_exp_o, 32'h100);
`endif

      // Run 3: reset one cycle after a mismatching vector discards it.
      pulse_start();
      @(negedge clk_i);
      drive(ALU_ADD, 32'd1, 32'd1, 32'd3, 1'b0, 1'b0);
      @(negedge clk_i); valid_i = 1'b0; rst_i = 1'b1;
      @(negedge clk_i); rst_i = 1'b0;
      void'(exp_q.pop_front());
      m_chk = 0; m_skip = 0; m_err = 0; m_errf = 1'b0;
      check_counts("rst_mid");
      chk("rst_mid.busy", 32'(busy_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check_counts("rst_mid_later");
`ifdef IBEX_ALU_CHK_CAPTURE_EN
      chk("rst_mid.cap_got", fail_got_o, 32'h0);
`endif

      // Run 4: back-to-back random ADDs, one per cycle.
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = $urandom;
         @(negedge clk_i);
         drive(ALU_ADD, a, b, a + b, 1'b0, a == b);
      end
      @(negedge clk_i); valid_i = 1'b0;
      @(negedge clk_i);
      while (exp_q.size() != 0) retire();
      check_counts("b2b");
      chk("b2b.check_cnt", 32'(check_cnt_o), 32'd4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
